ahb_mtx_input_stage_hold: RTL and testbench
===========================================

# ahb_mtx_input_stage_hold

Master-side input stage of the AHB bus matrix: one instance per matrix input port, sitting between an AHB-Lite master and the per-slave output-stage arbiters. It raises a request to the output stage for every address-phase transfer and registers any transfer the output stage cannot accept immediately. It stalls the master (HREADYOUTS low) until the held transfer has been issued and completed. It returns the selected slave's data-phase response to the master.

## Interface
- ADDR_WIDTH, 32, address bus width.
- HCLK  in  1  AHB clock; all state updates on rising edge.
- HRESETn  in  1  reset, asynchronous, active-low.
- HSELS  in  1  master-side select for this port.
- HADDRS  in  ADDR_WIDTH  master address.
- HTRANSS  in  2  master transfer type.
- HWRITES  in  1  master write flag.
- HSIZES  in  3  master transfer size.
- HBURSTS  in  3  master burst type.
- HPROTS  in  4  master protection.
- HMASTLOCKS  in  1  master lock.
- HREADYS  in  1  master-side bus HREADY (address-phase sample qualifier).
- HREADYOUTS  out  1  ready returned to master.
- HRESPS  out  1  response returned to master (0 OKAY, 1 ERROR).
- trans_pend  out  1  request to output stage: a transfer is presented.
- HADDRM, HTRANSM, HWRITEM, HSIZEM, HBURSTM, HPROTM, HMASTLOCKM  out  widths as master-side  transfer presented to output stage.
- addr_in_phase  in  1  output stage has this port selected for address phase this cycle.
- data_in_phase  in  1  output stage has this port in data phase this cycle.
- HREADYM  in  1  ready from the output stage/slave.
- HRESPM  in  1  response from the output stage/slave.

## Operation
- new_tran = HSELS & HTRANSS[1] & HREADYS (NONSEQ or SEQ sampled from master).
- accepted = addr_in_phase & HREADYM.
- State reg_hold (1 bit): EMPTY (0) / HELD (1).
- EMPTY -> HELD: new_tran & !accepted. Capture HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS, HMASTLOCKS into the hold register.
- EMPTY stays EMPTY when new_tran & accepted. The transfer passes straight through.
- HELD -> EMPTY: accepted. Hold register contents are then don't-care.
- HELD stays HELD while !accepted. The hold register is not overwritten. While HREADYOUTS=0 the master cannot present a new transfer, so new_tran in HELD is a protocol violation: ignore it.
- Output mux: HELD drives all *M outputs from the hold register. EMPTY drives them from the live *S inputs, except HTRANSM = HSELS ? HTRANSS : IDLE.
- trans_pend = reg_hold | (HSELS & HTRANSS[1]).
- HREADYOUTS = reg_hold ? 0 : (data_in_phase ? HREADYM : 1).
- HRESPS = (!reg_hold & data_in_phase) ? HRESPM : 0.
- BUSY and IDLE are never held. They pass through live in EMPTY.
- Two-cycle ERROR response: the first cycle (HRESPM=1, HREADYM=0) and second cycle are forwarded unchanged. If the master drives IDLE on the second cycle, nothing is captured.
- HMASTLOCKM stays asserted while HELD with a locked held transfer.

## Timing
- Reset values: reg_hold=0; hold register all zeros; HREADYOUTS=1; HRESPS=0; trans_pend=0 (with HSELS=0); HTRANSM=IDLE.
- Pass-through latency 0: a granted address phase reaches the output in the same cycle.
- Held transfer: earliest issue is the cycle after capture. Master stall = number of cycles until accepted, plus the data-phase wait states.
- The hold register is written only on the EMPTY->HELD edge. reg_hold updates every cycle, not gated by HREADYS.
- Simultaneous capture and accept within one cycle is impossible by construction (accepted blocks capture).
- Reset asserted mid-HELD discards the held transfer asynchronously. Outputs return to reset values immediately.

## Test plan
- Reset: HRESETn low with random inputs -> HREADYOUTS=1, HRESPS=0, HTRANSM=00, trans_pend=0.
- Pass-through: NONSEQ to 0x0000_1000 with addr_in_phase=1, HREADYM=1 -> same-cycle HADDRM=0x1000, HTRANSM=10; reg_hold stays 0; next cycle data_in_phase with HREADYM=1 -> HREADYOUTS=1.
- Hold: NONSEQ write 0x2000 INCR4 with addr_in_phase=0 for 3 cycles then 1 -> HREADYOUTS=0 for 3 cycles; HADDRM=0x2000, HBURSTM=011 held throughout; trans_pend=1; hold clears on the 4th cycle.
- Held data wait: after the hold clears, data_in_phase=1 with HREADYM 0,0,1 -> HREADYOUTS 0,0,1.
- Error: data_in_phase=1 with HRESPM=1, HREADYM 0 then 1 and master IDLE -> HRESPS=1 for both cycles, HREADYOUTS 0 then 1, no capture.
- Reset mid-hold: HELD with HMASTLOCKM=1, HRESETn pulsed low -> HMASTLOCKM=0, HREADYOUTS=1 asynchronously.

Source files
------------

// File: rtl/ahb_mtx_input_stage_hold.sv
// ahb_mtx_input_stage_hold: bus-matrix master input stage; it holds any transfer that the output stage cannot take
// at once and stalls the master until that transfer has been issued.
module ahb_mtx_input_stage_hold #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSELS,
  input  logic [ADDR_WIDTH-1:0] HADDRS,
  input  logic [1:0]            HTRANSS,
  input  logic                  HWRITES,
  input  logic [2:0]            HSIZES,
  input  logic [2:0]            HBURSTS,
  input  logic [3:0]            HPROTS,
  input  logic                  HMASTLOCKS,
  input  logic                  HREADYS,
  output logic                  HREADYOUTS,
  output logic                  HRESPS,
  output logic                  trans_pend,
  output logic [ADDR_WIDTH-1:0] HADDRM,
  output logic [1:0]            HTRANSM,
  output logic                  HWRITEM,
  output logic [2:0]            HSIZEM,
  output logic [2:0]            HBURSTM,
  output logic [3:0]            HPROTM,
  output logic                  HMASTLOCKM,
  input  logic                  addr_in_phase,
  input  logic                  data_in_phase,
  input  logic                  HREADYM,
  input  logic                  HRESPM
);
  typedef enum logic {EMPTY = 1'b0, HELD = 1'b1} hold_e;
  hold_e state, state_nxt;
  logic                  reg_hold, new_tran, accepted, capture;
  logic [ADDR_WIDTH-1:0] hold_addr;
  logic [1:0]            hold_trans;
  logic                  hold_write, hold_lock;
  logic [2:0]            hold_size, hold_burst;
  logic [3:0]            hold_prot;
  assign reg_hold = state == HELD;
  assign new_tran = HSELS & HTRANSS[1] & HREADYS;
  assign accepted = addr_in_phase & HREADYM;
  // a new transfer seen while HELD is a master protocol violation and is dropped
  assign capture  = !reg_hold & new_tran & !accepted;
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      state      <= EMPTY;
      hold_addr  <= '0;
      hold_trans <= '0;
      hold_write <= 1'b0;
      hold_size  <= '0;
      hold_burst <= '0;
      hold_prot  <= '0;
      hold_lock  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        hold_addr  <= HADDRS;
        hold_trans <= HTRANSS;
        hold_write <= HWRITES;
        hold_size  <= HSIZES;
        hold_burst <= HBURSTS;
        hold_prot  <= HPROTS;
        hold_lock  <= HMASTLOCKS;
      end
    end
  always_comb begin
    state_nxt  = state;
    if (capture) state_nxt = HELD;
    else if (reg_hold && accepted) state_nxt = EMPTY;
    HADDRM     = reg_hold ? hold_addr  : HADDRS;
    HTRANSM    = reg_hold ? hold_trans : (HSELS ? HTRANSS : 2'b00);
    HWRITEM    = reg_hold ? hold_write : HWRITES;
    HSIZEM     = reg_hold ? hold_size  : HSIZES;
    HBURSTM    = reg_hold ? hold_burst : HBURSTS;
    HPROTM     = reg_hold ? hold_prot  : HPROTS;
    HMASTLOCKM = reg_hold ? hold_lock  : HMASTLOCKS;
    trans_pend = reg_hold | (HSELS & HTRANSS[1]);
    HREADYOUTS = reg_hold ? 1'b0 : (data_in_phase ? HREADYM : 1'b1);
    HRESPS     = !reg_hold & data_in_phase & HRESPM;
  end
endmodule

// File: tb/tb_ahb_mtx_input_stage_hold.sv
// tb_ahb_mtx_input_stage_hold: per-cycle vector table through a scoreboard queue, then async reset mid-hold.
module tb_ahb_mtx_input_stage_hold;
  logic        HCLK = 1'b0, HRESETn = 1'b0;
  logic        HSELS, HWRITES, HMASTLOCKS, HREADYS, addr_in_phase, data_in_phase, HREADYM, HRESPM;
  logic [31:0] HADDRS, HADDRM;
  logic [1:0]  HTRANSS, HTRANSM;
  logic [2:0]  HSIZES, HBURSTS, HSIZEM, HBURSTM;
  logic [3:0]  HPROTS, HPROTM;
  logic        HREADYOUTS, HRESPS, trans_pend, HWRITEM, HMASTLOCKM;
  int          checks = 0, errors = 0;

  typedef struct {
    logic sel; logic [31:0] addr; logic [1:0] trans; logic wr; logic [2:0] burst; logic lock;
    logic readys, aip, dip, readym, respm;
    logic e_rdy, e_resp, e_pend; logic [1:0] e_trans; logic [31:0] e_addr; logic [2:0] e_burst; logic e_lock, e_wr;
  } vec_t;
  vec_t vecs[18];
  vec_t sb[$];

  ahb_mtx_input_stage_hold #(.ADDR_WIDTH(32)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSELS(HSELS), .HADDRS(HADDRS), .HTRANSS(HTRANSS),
    .HWRITES(HWRITES), .HSIZES(HSIZES), .HBURSTS(HBURSTS), .HPROTS(HPROTS),
    .HMASTLOCKS(HMASTLOCKS), .HREADYS(HREADYS), .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS),
    .trans_pend(trans_pend), .HADDRM(HADDRM), .HTRANSM(HTRANSM), .HWRITEM(HWRITEM),
    .HSIZEM(HSIZEM), .HBURSTM(HBURSTM), .HPROTM(HPROTM), .HMASTLOCKM(HMASTLOCKM),
    .addr_in_phase(addr_in_phase), .data_in_phase(data_in_phase), .HREADYM(HREADYM), .HRESPM(HRESPM)
  );

  always #5 HCLK = ~HCLK;

  function automatic vec_t mk(logic sel, logic [31:0] addr, logic [1:0] trans, logic wr, logic [2:0] burst,
                              logic lock, logic readys, logic aip, logic dip, logic readym, logic respm,
                              logic e_rdy, logic e_resp, logic e_pend, logic [1:0] e_trans,
                              logic [31:0] e_addr, logic [2:0] e_burst, logic e_lock, logic e_wr);
    vec_t v;
    v.sel = sel; v.addr = addr; v.trans = trans; v.wr = wr; v.burst = burst; v.lock = lock;
    v.readys = readys; v.aip = aip; v.dip = dip; v.readym = readym; v.respm = respm;
    v.e_rdy = e_rdy; v.e_resp = e_resp; v.e_pend = e_pend; v.e_trans = e_trans;
    v.e_addr = e_addr; v.e_burst = e_burst; v.e_lock = e_lock; v.e_wr = e_wr;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    HSELS = v.sel; HADDRS = v.addr; HTRANSS = v.trans; HWRITES = v.wr; HBURSTS = v.burst;
    HMASTLOCKS = v.lock; HREADYS = v.readys; addr_in_phase = v.aip; data_in_phase = v.dip;
    HREADYM = v.readym; HRESPM = v.respm; HSIZES = 3'b010; HPROTS = 4'b0011;
    sb.push_back(v);
  endtask

  task automatic compare_out(input int idx);
    vec_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard step %0d: got empty queue expected an entry", idx);
      return;
    end
    e = sb.pop_front();
    chk("HREADYOUTS", idx, {31'b0, HREADYOUTS}, {31'b0, e.e_rdy});
    chk("HRESPS", idx, {31'b0, HRESPS}, {31'b0, e.e_resp});
    chk("trans_pend", idx, {31'b0, trans_pend}, {31'b0, e.e_pend});
    chk("HTRANSM", idx, {30'b0, HTRANSM}, {30'b0, e.e_trans});
    chk("HADDRM", idx, HADDRM, e.e_addr);
    chk("HBURSTM", idx, {29'b0, HBURSTM}, {29'b0, e.e_burst});
    chk("HMASTLOCKM", idx, {31'b0, HMASTLOCKM}, {31'b0, e.e_lock});
    chk("HWRITEM", idx, {31'b0, HWRITEM}, {31'b0, e.e_wr});
  endtask

  initial begin
    vec_t r;
    // idle, pass-through, data phase
    vecs[0]  = mk(1,32'h0000,2'b00,0,0,0, 1,0,0,1,0, 1,0,1,2'b00,32'h0000,0,0,0);
    vecs[0]  = mk(0,32'h0000,2'b00,0,0,0, 1,0,0,1,0, 1,0,0,2'b00,32'h0000,0,0,0);
    vecs[1]  = mk(1,32'h1000,2'b10,0,0,0, 1,1,0,1,0, 1,0,1,2'b10,32'h1000,0,0,0);
    vecs[2]  = mk(0,32'h0000,2'b00,0,0,0, 1,0,1,1,0, 1,0,0,2'b00,32'h0000,0,0,0);
    // INCR4 write to 0x2000 captured, not accepted for 3 cycles
    vecs[3]  = mk(1,32'h2000,2'b10,1,3,0, 1,0,0,1,0, 1,0,1,2'b10,32'h2000,3,0,1);
    vecs[4]  = mk(1,32'h3000,2'b10,0,0,0, 0,0,0,1,0, 0,0,1,2'b10,32'h2000,3,0,1);
    vecs[5]  = mk(1,32'h3000,2'b10,0,0,0, 0,0,0,1,0, 0,0,1,2'b10,32'h2000,3,0,1);
    vecs[6]  = mk(1,32'h3000,2'b10,0,0,0, 0,1,0,1,0, 0,0,1,2'b10,32'h2000,3,0,1);
    // data phase of the held transfer with two wait states
    vecs[7]  = mk(0,32'h0000,2'b00,0,0,0, 0,0,1,0,0, 0,0,0,2'b00,32'h0000,0,0,0);
    vecs[8]  = mk(0,32'h0000,2'b00,0,0,0, 0,0,1,0,0, 0,0,0,2'b00,32'h0000,0,0,0);
    vecs[9]  = mk(0,32'h0000,2'b00,0,0,0, 1,0,1,1,0, 1,0,0,2'b00,32'h0000,0,0,0);
    // two-cycle ERROR, master goes IDLE on the second cycle
    vecs[10] = mk(1,32'h4000,2'b10,0,0,0, 0,0,1,0,1, 0,1,1,2'b10,32'h4000,0,0,0);
    vecs[11] = mk(1,32'h4000,2'b00,0,0,0, 1,0,1,1,1, 1,1,0,2'b00,32'h4000,0,0,0);
    vecs[12] = mk(0,32'h0000,2'b00,0,0,0, 1,0,0,1,0, 1,0,0,2'b00,32'h0000,0,0,0);
    // BUSY passes through and is never held
    vecs[13] = mk(1,32'h4800,2'b01,0,0,0, 1,0,0,1,0, 1,0,0,2'b01,32'h4800,0,0,0);
    vecs[14] = mk(0,32'h0000,2'b00,0,0,0, 1,0,0,1,0, 1,0,0,2'b00,32'h0000,0,0,0);
    // locked transfer held; a new transfer while HELD must be ignored
    vecs[15] = mk(1,32'h5000,2'b10,0,1,1, 1,0,0,1,0, 1,0,1,2'b10,32'h5000,1,1,0);
    vecs[16] = mk(1,32'h6000,2'b10,1,0,0, 1,0,0,1,0, 0,0,1,2'b10,32'h5000,1,1,0);
    vecs[17] = mk(0,32'h0000,2'b00,0,0,0, 0,0,0,1,0, 0,0,1,2'b10,32'h5000,1,1,0);

    // reset with random inputs (select and data phase kept low)
    for (int i = 0; i < 3; i++) begin
      r = mk(0, $urandom, 2'($urandom), 1'($urandom), 3'($urandom), 1'($urandom),
             1'($urandom), 1'($urandom), 0, 1'($urandom), 1'($urandom), 1,0,0,2'b00,32'h0,0,0,0);
      r.e_addr = r.addr; r.e_burst = r.burst; r.e_lock = r.lock; r.e_wr = r.wr;
      drive(r);
      #3;
      compare_out(100 + i);
    end
    @(negedge HCLK);
    HRESETn = 1'b1;
    for (int i = 0; i < 18; i++) begin
      if (i != 0) @(negedge HCLK);
      drive(vecs[i]);
      #1;
      compare_out(i);
    end
    // asynchronous reset mid-hold: held lock and stall drop immediately
    #2;
    HRESETn = 1'b0;
    r = vecs[17];
    r.e_rdy = 1; r.e_pend = 0; r.e_trans = 2'b00; r.e_addr = 32'h0; r.e_burst = 0; r.e_lock = 0; r.e_wr = 0;
    sb.push_back(r);
    #1;
    compare_out(200);
    @(negedge HCLK);
    HRESETn = 1'b1;
    @(negedge HCLK);
    drive(r);
    #1;
    compare_out(201);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
